// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial subtractor.
// The master drives requests; the slave (the subtractor) returns status and results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (output start, a_in, b_in, input busy, done, diff, borrow);
    modport slave  (input start, a_in, b_in, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: DIFF = A - B, LSB first, one full-subtractor step per clock.
// Results land in diff/borrow only on DONE entry, so partial sums never leak out.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, d_sr_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, borrow_q, busy_q, done_q;

    logic             d_bit;
    logic             br_d;
    logic [WIDTH-1:0] d_sr_d;

    // Full-subtractor cell on the current LSBs with the registered borrow.
    always_comb begin
        d_bit  = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
        br_d   = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
        d_sr_d = {d_bit, d_sr_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            d_sr_q   <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sr_q  <= bus.a_in;
                        b_sr_q  <= bus.b_in;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    d_sr_q <= d_sr_d;
                    br_q   <= br_d;
                    cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        diff_q   <= d_sr_d;
                        borrow_q <= br_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
endmodule
